router_activity_monitor: RTL and testbench

- Parametrised statistics, idle-detect and drain-check unit instantiated beside each router.
- Consumes the per-port router event strobes and the per-IVC request flags.
- Keeps saturating per-port flit, packet and bypass counters, with a snapshot bank read through a registered mux.
- Flags router quiescence and runs a drain handshake with timeout that reports which IVCs remain occupied.

---
 rtl/router_activity_monitor.sv | 168 ++++++++++++++++
 tb/tb_router_activity_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_activity_monitor.sv
// Per-router statistics, idle detection and drain check.
// Saturating per-port event counters with a snapshot bank, a quiescence flag and a drain/timeout FSM.
module router_activity_monitor #(
    parameter int P             = 5,
    parameter int V             = 4,
    parameter int CNTw          = 32,
    parameter int IDLE_CYCLES   = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [P-1:0]                        flit_wr_i,
    input  logic [P-1:0]                        pck_wr_i,
    input  logic [P-1:0]                        flit_wr_o,
    input  logic [P-1:0]                        pck_wr_o,
    input  logic [P-1:0]                        bypassed_i,
    input  logic [P*V-1:0]                      ivc_req,
    input  logic                                clear,
    input  logic                                snap,
    input  logic [((P > 1) ? $clog2(P) : 1)-1:0] rd_port,
    input  logic [2:0]                          rd_sel,
    output logic [CNTw-1:0]                     rd_data,
    output logic                                router_idle,
    input  logic                                drain_req,
    output logic                                drain_busy,
    output logic                                drain_done,
    output logic                                drain_timeout,
    output logic [P*V-1:0]                      stuck_ivc
);
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT);
    localparam int NK = 5;

    localparam logic [1:0] D_OFF  = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_DONE = 2'd2;
    localparam logic [1:0] D_TOUT = 2'd3;

    // Counter kind k occupies row k: flit_in, pck_in, flit_out, pck_out, bypassed.
    logic [NK-1:0][P-1:0]    w_strobe;
    logic [NK*P*CNTw-1:0]    w_snap_flat;
    logic [CNTw-1:0]         w_rd_next;

    assign w_strobe = {bypassed_i, pck_wr_o, flit_wr_o, pck_wr_i, flit_wr_i};

    genvar gk, gi;
    generate
        for (gk = 0; gk < NK; gk++) begin : g_kind
            for (gi = 0; gi < P; gi++) begin : g_port
                logic [CNTw-1:0] r_live;
                logic [CNTw-1:0] r_snap;

                always_ff @(posedge clk) begin
                    if (reset || clear) begin
                        r_live <= '0;
                    end else if (w_strobe[gk][gi] && (r_live != {CNTw{1'b1}})) begin
                        r_live <= r_live + CNTw'(1);
                    end
                end

                // Snapshot takes the pre-update value, so snap+clear keeps the old count.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_snap <= '0;
                    end else if (snap) begin
                        r_snap <= r_live;
                    end
                end

                assign w_snap_flat[(gk*P+gi)*CNTw +: CNTw] = r_snap;
            end
        end
    endgenerate

    always_comb begin
        w_rd_next = '0;
        for (int k = 0; k < NK; k++) begin
            for (int p = 0; p < P; p++) begin
                if ((rd_sel == 3'(k)) && (rd_port == PW'(p))) begin
                    w_rd_next = w_snap_flat[(k*P+p)*CNTw +: CNTw];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_rd_next;
        end
    end

    logic          w_active;
    logic [IW-1:0] r_idle_cnt;
    logic [IW-1:0] w_idle_next;

    assign w_active    = (|flit_wr_i) | (|flit_wr_o) | (|ivc_req);
    assign w_idle_next = w_active ? '0 :
                         (r_idle_cnt == IW'(IDLE_CYCLES)) ? r_idle_cnt : r_idle_cnt + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt  <= '0;
            router_idle <= 1'b0;
        end else begin
            r_idle_cnt  <= w_idle_next;
            router_idle <= (w_idle_next == IW'(IDLE_CYCLES));
        end
    end

    logic [1:0]     r_state, w_state_next;
    logic [TW-1:0]  r_timer, w_timer_next;
    logic [P*V-1:0] w_stuck_next;

    // A drain only starts from D_OFF, which D_DONE/D_TOUT reach only once drain_req drops.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_stuck_next = stuck_ivc;
        case (r_state)
            D_OFF: begin
                if (drain_req) begin
                    w_state_next = D_WAIT;
                    w_timer_next = '0;
                    w_stuck_next = '0;
                end
            end
            D_WAIT: begin
                if (!drain_req) begin
                    w_state_next = D_OFF;
                end else if (router_idle) begin
                    w_state_next = D_DONE;
                end else if (r_timer == TW'(DRAIN_TIMEOUT - 1)) begin
                    w_state_next = D_TOUT;
                    w_stuck_next = ivc_req;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            D_DONE, D_TOUT: begin
                if (!drain_req) begin
                    w_state_next = D_OFF;
                end
            end
            default: w_state_next = D_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= D_OFF;
            r_timer       <= '0;
            stuck_ivc     <= '0;
            drain_busy    <= 1'b0;
            drain_done    <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            stuck_ivc     <= w_stuck_next;
            drain_busy    <= (w_state_next == D_WAIT);
            drain_done    <= (w_state_next == D_DONE);
            drain_timeout <= (w_state_next == D_TOUT);
        end
    end
endmodule

// File: tb/tb_router_activity_monitor.sv
// Directed bench for router_activity_monitor (CNTw=4, DRAIN_TIMEOUT=16).
module tb_router_activity_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  flit_wr_i, pck_wr_i, flit_wr_o, pck_wr_o, bypassed_i;
    logic [19:0] ivc_req;
    logic        clear, snap;
    logic [2:0]  rd_port, rd_sel;
    logic [3:0]  rd_data;
    logic        router_idle, drain_req, drain_busy, drain_done, drain_timeout;
    logic [19:0] stuck_ivc;

    int errors = 0;
    int checks = 0;

    router_activity_monitor #(
        .P(5), .V(4), .CNTw(4), .IDLE_CYCLES(4), .DRAIN_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .flit_wr_i(flit_wr_i), .pck_wr_i(pck_wr_i), .flit_wr_o(flit_wr_o),
        .pck_wr_o(pck_wr_o), .bypassed_i(bypassed_i), .ivc_req(ivc_req),
        .clear(clear), .snap(snap), .rd_port(rd_port), .rd_sel(rd_sel),
        .rd_data(rd_data), .router_idle(router_idle), .drain_req(drain_req),
        .drain_busy(drain_busy), .drain_done(drain_done),
        .drain_timeout(drain_timeout), .stuck_ivc(stuck_ivc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        flit_wr_i = '0; pck_wr_i = '0; flit_wr_o = '0; pck_wr_o = '0; bypassed_i = '0;
        ivc_req = '0; clear = 0; snap = 0; rd_port = '0; rd_sel = '0; drain_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; flit_wr_i = '1; ivc_req = '1; drain_req = 1; snap = 1;
        tick(); tick();
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end else $display("ok reset_rd_data");
        checks++; if (router_idle !== 1'b0) begin errors++; $display("FAIL reset_idle: got %0b expected 0", router_idle); end else $display("ok reset_idle");
        checks++; if ({drain_busy, drain_done, drain_timeout} !== 3'b000) begin errors++; $display("FAIL reset_drain: got %03b expected 000", {drain_busy, drain_done, drain_timeout}); end else $display("ok reset_drain");
        checks++; if (stuck_ivc !== 20'h0) begin errors++; $display("FAIL reset_stuck: got %0h expected 0", stuck_ivc); end else $display("ok reset_stuck");
        clr_in();
        reset = 0;
    endtask

    task automatic test_counters();
        flit_wr_i = 5'b00100; pck_wr_i = 5'b00100; bypassed_i = 5'b10000;
        tick();
        pck_wr_i = '0;
        tick();
        bypassed_i = '0;
        tick();
        flit_wr_i = '0; snap = 1;
        tick();
        snap = 0; rd_port = 3'd2; rd_sel = 3'd0;
        tick();
        checks++; if (rd_data !== 4'd3) begin errors++; $display("FAIL rd_flit_in_p2: got %0d expected 3", rd_data); end else $display("ok rd_flit_in_p2 = %0d", rd_data);
        rd_sel = 3'd1;
        tick();
        checks++; if (rd_data !== 4'd1) begin errors++; $display("FAIL rd_pck_in_p2: got %0d expected 1", rd_data); end else $display("ok rd_pck_in_p2 = %0d", rd_data);
        rd_port = 3'd4; rd_sel = 3'd4;
        tick();
        checks++; if (rd_data !== 4'd2) begin errors++; $display("FAIL rd_bypass_p4: got %0d expected 2", rd_data); end else $display("ok rd_bypass_p4 = %0d", rd_data);
        rd_port = 3'd5; rd_sel = 3'd0;
        tick();
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL rd_port_oob: got %0d expected 0", rd_data); end else $display("ok rd_port_oob = %0d", rd_data);
        rd_port = 3'd2; rd_sel = 3'd5;
        tick();
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL rd_sel_oob: got %0d expected 0", rd_data); end else $display("ok rd_sel_oob = %0d", rd_data);
    endtask

    task automatic test_saturation();
        flit_wr_o = 5'b00001;
        repeat (20) tick();
        flit_wr_o = '0; snap = 1;
        tick();
        snap = 0; rd_port = 3'd0; rd_sel = 3'd2;
        tick();
        checks++; if (rd_data !== 4'd15) begin errors++; $display("FAIL sat_flit_out_p0: got %0d expected 15", rd_data); end else $display("ok sat_flit_out_p0 = %0d", rd_data);
        clear = 1; flit_wr_o = 5'b00001;
        tick();
        clear = 0; flit_wr_o = '0; snap = 1;
        tick();
        snap = 0;
        tick();
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL clear_flit_out_p0: got %0d expected 0", rd_data); end else $display("ok clear_flit_out_p0 = %0d", rd_data);
    endtask

    task automatic test_snap_clear();
        flit_wr_i = 5'b00010;
        repeat (7) tick();
        snap = 1; clear = 1;
        tick();
        snap = 0; clear = 0; flit_wr_i = '0; rd_port = 3'd1; rd_sel = 3'd0;
        tick();
        checks++; if (rd_data !== 4'd7) begin errors++; $display("FAIL snapclr_flit_in_p1: got %0d expected 7", rd_data); end else $display("ok snapclr_flit_in_p1 = %0d", rd_data);
        snap = 1;
        tick();
        checks++; if (rd_data !== 4'd7) begin errors++; $display("FAIL read_during_snap: got %0d expected 7", rd_data); end else $display("ok read_during_snap = %0d", rd_data);
        snap = 0;
        tick();
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL live_after_clear: got %0d expected 0", rd_data); end else $display("ok live_after_clear = %0d", rd_data);
    endtask

    task automatic test_idle();
        flit_wr_i = 5'b00001;
        repeat (10) tick();
        flit_wr_i = '0;
        checks++; if (router_idle !== 1'b0) begin errors++; $display("FAIL idle_while_active: got %0b expected 0", router_idle); end else $display("ok idle_while_active");
        repeat (3) tick();
        checks++; if (router_idle !== 1'b0) begin errors++; $display("FAIL idle_early_3: got %0b expected 0", router_idle); end else $display("ok idle_early_3");
        tick();
        checks++; if (router_idle !== 1'b1) begin errors++; $display("FAIL idle_at_4: got %0b expected 1", router_idle); end else $display("ok idle_at_4");
        ivc_req = 20'h00001;
        tick();
        checks++; if (router_idle !== 1'b0) begin errors++; $display("FAIL idle_drop_ivc: got %0b expected 0", router_idle); end else $display("ok idle_drop_ivc");
        ivc_req = '0;
        repeat (3) tick();
        checks++; if (router_idle !== 1'b0) begin errors++; $display("FAIL idle_reearly_3: got %0b expected 0", router_idle); end else $display("ok idle_reearly_3");
        tick();
        checks++; if (router_idle !== 1'b1) begin errors++; $display("FAIL idle_again_4: got %0b expected 1", router_idle); end else $display("ok idle_again_4");
    endtask

    task automatic test_drain_timeout();
        ivc_req = 20'h00040; drain_req = 1;
        tick();
        checks++; if ({drain_busy, drain_timeout} !== 2'b10) begin errors++; $display("FAIL tout_busy_0: got %02b expected 10", {drain_busy, drain_timeout}); end else $display("ok tout_busy_0");
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if ({drain_busy, drain_timeout} !== 2'b10) begin errors++; $display("FAIL tout_busy_%0d: got %02b expected 10", i, {drain_busy, drain_timeout}); end
        end
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout} !== 3'b001) begin errors++; $display("FAIL tout_flag: got %03b expected 001", {drain_busy, drain_done, drain_timeout}); end else $display("ok tout_flag");
        checks++; if (stuck_ivc !== 20'h00040) begin errors++; $display("FAIL tout_stuck: got %0h expected 40", stuck_ivc); end else $display("ok tout_stuck = %0h", stuck_ivc);
        ivc_req = '0;
        tick(); tick();
        checks++; if ({drain_timeout, stuck_ivc} !== {1'b1, 20'h00040}) begin errors++; $display("FAIL tout_hold: got %0b/%0h expected 1/40", drain_timeout, stuck_ivc); end else $display("ok tout_hold");
        drain_req = 0;
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout} !== 3'b000) begin errors++; $display("FAIL tout_release: got %03b expected 000", {drain_busy, drain_done, drain_timeout}); end else $display("ok tout_release");
        checks++; if (stuck_ivc !== 20'h00040) begin errors++; $display("FAIL stuck_kept: got %0h expected 40", stuck_ivc); end else $display("ok stuck_kept");
    endtask

    task automatic test_drain_done();
        ivc_req = 20'h00001; drain_req = 1;
        tick();
        checks++; if ({drain_busy, stuck_ivc} !== {1'b1, 20'h0}) begin errors++; $display("FAIL done_start: got %0b/%0h expected 1/0", drain_busy, stuck_ivc); end else $display("ok done_start");
        ivc_req = '0;
        repeat (4) tick();
        checks++; if ({router_idle, drain_busy, drain_done} !== 3'b110) begin errors++; $display("FAIL done_pre: got %03b expected 110", {router_idle, drain_busy, drain_done}); end else $display("ok done_pre");
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout} !== 3'b010) begin errors++; $display("FAIL done_flag: got %03b expected 010", {drain_busy, drain_done, drain_timeout}); end else $display("ok done_flag");
        repeat (3) tick();
        checks++; if ({drain_busy, drain_done} !== 2'b01) begin errors++; $display("FAIL done_no_restart: got %02b expected 01", {drain_busy, drain_done}); end else $display("ok done_no_restart");
        drain_req = 0;
        tick();
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL done_release: got %0b expected 0", drain_done); end else $display("ok done_release");
        drain_req = 1;
        tick();
        checks++; if (drain_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %0b expected 1", drain_busy); end else $display("ok b2b_restart");
        tick();
        checks++; if ({drain_busy, drain_done} !== 2'b01) begin errors++; $display("FAIL b2b_done: got %02b expected 01", {drain_busy, drain_done}); end else $display("ok b2b_done");
    endtask

    task automatic test_drain_abort();
        drain_req = 0;
        tick();
        ivc_req = 20'h80000; drain_req = 1;
        tick();
        repeat (3) tick();
        checks++; if (drain_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %0b expected 1", drain_busy); end else $display("ok abort_busy");
        drain_req = 0;
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout} !== 3'b000) begin errors++; $display("FAIL abort_off: got %03b expected 000", {drain_busy, drain_done, drain_timeout}); end else $display("ok abort_off");
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout} !== 3'b000) begin errors++; $display("FAIL abort_stay: got %03b expected 000", {drain_busy, drain_done, drain_timeout}); end else $display("ok abort_stay");
        ivc_req = '0;
    endtask

    task automatic test_reset_mid_drain();
        flit_wr_i = 5'b01000;
        tick();
        flit_wr_i = '0; snap = 1;
        tick();
        snap = 0; rd_port = 3'd3; rd_sel = 3'd0;
        tick();
        checks++; if (rd_data !== 4'd1) begin errors++; $display("FAIL rd_flit_in_p3: got %0d expected 1", rd_data); end else $display("ok rd_flit_in_p3 = %0d", rd_data);
        ivc_req = 20'h00001; drain_req = 1;
        tick();
        tick(); tick();
        checks++; if (drain_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %0b expected 1", drain_busy); end else $display("ok rst_pre_busy");
        reset = 1;
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout, router_idle, rd_data} !== 8'h00) begin errors++; $display("FAIL rst_mid_drain: got %02h expected 00", {drain_busy, drain_done, drain_timeout, router_idle, rd_data}); end else $display("ok rst_mid_drain");
        reset = 0; drain_req = 0; ivc_req = '0;
        tick();
        checks++; if ({drain_busy, drain_done, drain_timeout, rd_data} !== 7'h00) begin errors++; $display("FAIL rst_after: got %02h expected 00", {drain_busy, drain_done, drain_timeout, rd_data}); end else $display("ok rst_after (snapshot cleared)");
        tick(); tick();
        checks++; if (router_idle !== 1'b0) begin errors++; $display("FAIL rst_idle_3: got %0b expected 0", router_idle); end else $display("ok rst_idle_3");
        tick();
        checks++; if (router_idle !== 1'b1) begin errors++; $display("FAIL rst_idle_4: got %0b expected 1", router_idle); end else $display("ok rst_idle_4");
    endtask

    initial begin
        clr_in();
        reset = 1;
        test_reset();
        test_counters();
        test_saturation();
        test_snap_clear();
        test_idle();
        test_drain_timeout();
        test_drain_done();
        test_drain_abort();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
